// File: rtl/turn_signal_pkg.sv
// Shared types and helpers for the tail-light sequencer: state encoding
// and the per-lamp sweep decode.
package turn_signal_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_HAZARD = 2'd1,
    ST_LEFT   = 2'd2,
    ST_RIGHT  = 2'd3
  } state_e;

  // One bit of the sweep pattern (1<<step)-1: lamp 'lamp' is lit once the sweep has passed it.
  function automatic logic sweep_lit(input int unsigned lamp, input int unsigned step);
    return (lamp < step);
  endfunction

endpackage

// File: rtl/blink_tick_gen.sv
// Blink-rate divider: pulses tick once every DIV enabled cycles; clear
// restarts the count so the first tick lands exactly DIV cycles later.
module blink_tick_gen #(
  parameter int DIV = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    tick       = 1'b0;
    if (clear) begin
      tick_cnt_d = '0;
    end else if (enable) begin
      if (tick_cnt_q == LAST) begin
        tick_cnt_d = '0;
        tick       = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick_cnt_d;
  end

endmodule

// File: rtl/turn_signal_seq.sv
// Tail-light sequencer: hazard/left/right FSM with sweep or flash pattern,
// brake overlay on non-signalling sides, and a state code for HEX0.
module turn_signal_seq
  import turn_signal_pkg::*;
#(
  parameter int LAMPS = 3,
  parameter int DIV   = 5000000
) (
  input  logic             ADC_CLK_10,
  input  logic             reset,
  input  logic             hazard,
  input  logic             turn_en,
  input  logic             turn_dir,
  input  logic             brake,
  input  logic             seq_mode,
  output logic [LAMPS-1:0] left_lamps,
  output logic [LAMPS-1:0] right_lamps,
  output logic [1:0]       state_code
);

  localparam int STEP_W = $clog2(LAMPS + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LAMPS);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              brake_q, seq_q;
  logic              restart, tick, sweep_step;
  logic [LAMPS-1:0]  pattern, brake_lamps;

  always_comb begin
    state_d = ST_IDLE;
    if (hazard)       state_d = ST_HAZARD;
    else if (turn_en) state_d = turn_dir ? ST_RIGHT : ST_LEFT;
  end

  // Any state change, including a direction swap, restarts the pattern dark.
  assign restart = (state_d != state_q);

  blink_tick_gen #(.DIV(DIV)) u_tick (
    .clk    (ADC_CLK_10),
    .rst    (reset),
    .clear  (restart),
    .enable (1'b1),
    .tick   (tick)
  );

  assign sweep_step = seq_mode && (state_q != ST_HAZARD);

  always_comb begin
    step_d = step_q;
    if (restart || state_q == ST_IDLE) begin
      step_d = '0;
    end else if (tick) begin
      if (sweep_step) step_d = (step_q == STEP_LAST) ? '0 : step_q + STEP_ONE;
      else            step_d = (step_q == '0) ? STEP_ONE : '0;
    end
  end

  always_ff @(posedge ADC_CLK_10) begin
    if (reset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      brake_q <= 1'b0;
      seq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      brake_q <= brake;
      seq_q   <= seq_mode;
    end
  end

  // Pattern follows the registered mode so outputs only move on a clock edge.
  always_comb begin
    pattern = '0;
    for (int i = 0; i < LAMPS; i++) begin
      if (seq_q && state_q != ST_HAZARD) pattern[i] = sweep_lit(i, int'(step_q));
      else                               pattern[i] = (step_q == STEP_ONE);
    end
  end

  assign brake_lamps = brake_q ? '1 : '0;

  always_comb begin
    left_lamps  = brake_lamps;
    right_lamps = brake_lamps;
    case (state_q)
      ST_HAZARD: begin
        left_lamps  = pattern;
        right_lamps = pattern;
      end
      ST_LEFT:  left_lamps  = pattern;
      ST_RIGHT: right_lamps = pattern;
      default: ;
    endcase
  end

  assign state_code = state_q;

endmodule
